dadda_mul_pipe: RTL and testbench

//  Parametrised, pipelined Dadda-tree multiplier: WIDTH x WIDTH -> 2*WIDTH product.

---
 rtl/dadda_mul_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_dadda_mul_pipe.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mul_pipe.sv
// dadda_mul_pipe
//   Pipelined WIDTH x WIDTH -> 2*WIDTH multiplier. Partial-product rows are
//   reduced by layers of 3:2 carry-save compressors down to two rows. A final
//   ripple adder in the last stage produces the product. The reduction layers
//   are spread evenly across STAGES register stages. Every beat uses
//   valid/ready handshakes, and a sideband tag travels with each beat.
//
//   Optional feature macro: DADDA_SIGNED_EN
//     defined     : tc_i=1 selects signed (Baugh-Wooley) partial products.
//     not defined : tc_i is ignored and every beat is unsigned.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush_i    synchronous flush; clears all stage valid bits
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle
//   a_i, b_i   operands (WIDTH bits each)
//   tag_i      sideband tag
//   tc_i       two's-complement mode for this beat
//   out_valid  product valid
//   out_ready  downstream accepts product
//   z_o        product (2*WIDTH bits)
//   tag_o      tag of the beat in z_o
module dadda_mul_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic               tc_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z_o,
    output logic [TAG_W-1:0]   tag_o
);

    localparam int unsigned W    = WIDTH;
    localparam int unsigned NS   = STAGES;
    localparam int unsigned PW   = 2 * WIDTH;
    // One row per multiplier bit, plus one row for the signed correction constant.
    localparam int unsigned MAXR = WIDTH + 1;

    typedef logic [MAXR-1:0][PW-1:0] rows_t;

    // Number of live rows after k compressor layers.
    function automatic int unsigned rows_after(int unsigned k);
        int unsigned n;
        n = MAXR;
        for (int unsigned i = 0; i < k; i++) n = n - n / 3;
        return n;
    endfunction

    function automatic int unsigned count_layers();
        int unsigned n;
        int unsigned l;
        n = MAXR;
        l = 0;
        while (n > 2) begin
            n = n - n / 3;
            l++;
        end
        return l;
    endfunction

    localparam int unsigned LAYERS = count_layers();

    // Index of the first layer handled by stage s.
    function automatic int unsigned lay_lo(int unsigned s);
        return (s * LAYERS) / NS;
    endfunction

    // One compressor layer: each group of three rows becomes a sum row and a
    // carry row. Leftover rows pass through unchanged. Live rows are packed
    // from index 0.
    function automatic rows_t csa_layer(rows_t r, int unsigned n);
        rows_t       o;
        int unsigned j;
        o = '0;
        j = 0;
        for (int unsigned i = 0; i + 2 < n; i += 3) begin
            o[j]   = r[i] ^ r[i+1] ^ r[i+2];
            o[j+1] = ((r[i] & r[i+1]) | (r[i] & r[i+2]) | (r[i+1] & r[i+2])) << 1;
            j += 2;
        end
        for (int unsigned i = n - n % 3; i < n; i++) begin
            o[j] = r[i];
            j++;
        end
        return o;
    endfunction

    function automatic rows_t reduce(rows_t r, int unsigned n, int unsigned nlay);
        rows_t       t;
        int unsigned m;
        t = r;
        m = n;
        for (int unsigned l = 0; l < nlay; l++) begin
            t = csa_layer(t, m);
            m = m - m / 3;
        end
        return t;
    endfunction

    logic tc;
`ifdef DADDA_SIGNED_EN
    assign tc = tc_i;
`else
    logic unused_tc;
    assign tc        = 1'b0;
    assign unused_tc = tc_i;
`endif

    // Partial products. In signed mode the MSB row and column are inverted,
    // except the MSB x MSB bit. The constant 2^W + 2^(2W-1) completes the
    // two's-complement sum.
    rows_t pp;
    always_comb begin
        pp = '0;
        for (int unsigned i = 0; i < W; i++) begin
            for (int unsigned j = 0; j < W; j++) begin
                pp[i][i+j] = (a_i[j] & b_i[i]) ^ (tc & ((i == W - 1) != (j == W - 1)));
            end
        end
        pp[W][W]    = tc;
        pp[W][PW-1] = tc;
    end

    logic [NS-1:0]    v;
    logic [NS:0]      en;
    logic [NS-1:0]    vin;
    logic             rdy_q;
    rows_t            row_q [NS];
    rows_t            red   [NS];
    rows_t            nxt   [NS];
    logic [TAG_W-1:0] tag_q [NS];
    logic [TAG_W-1:0] tin   [NS];
    logic [PW-1:0]    sum;

    // Stage s loads when it is empty or when the next stage moves.
    always_comb begin
        en[NS] = out_ready;
        for (int unsigned k = NS; k > 0; k--) en[k-1] = ~v[k-1] | en[k];
    end

    assign in_ready = rdy_q & en[0] & ~flush_i;

    always_comb begin
        vin[0] = in_valid & in_ready;
        tin[0] = tag_i;
        for (int unsigned s = 1; s < NS; s++) begin
            vin[s] = v[s-1];
            tin[s] = tag_q[s-1];
        end
    end

    // The last stage keeps its final sum in row 0. That row drives z_o.
    always_comb begin
        for (int unsigned s = 0; s < NS; s++) begin
            if (s == 0) red[s] = reduce(pp, rows_after(lay_lo(0)), lay_lo(1) - lay_lo(0));
            else        red[s] = reduce(row_q[s-1], rows_after(lay_lo(s)), lay_lo(s+1) - lay_lo(s));
        end
        sum = red[NS-1][0] + red[NS-1][1];
        for (int unsigned s = 0; s < NS; s++) nxt[s] = red[s];
        nxt[NS-1]    = '0;
        nxt[NS-1][0] = sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v     <= '0;
            rdy_q <= 1'b0;
            for (int unsigned s = 0; s < NS; s++) begin
                row_q[s] <= '0;
                tag_q[s] <= '0;
            end
        end else begin
            rdy_q <= 1'b1;
            for (int unsigned s = 0; s < NS; s++) begin
                if (flush_i)    v[s] <= 1'b0;
                else if (en[s]) v[s] <= vin[s];
                if (en[s] && vin[s]) begin
                    row_q[s] <= nxt[s];
                    tag_q[s] <= tin[s];
                end
            end
        end
    end

    assign out_valid = v[NS-1];
    assign z_o       = row_q[NS-1][0];
    assign tag_o     = tag_q[NS-1];

endmodule

// File: tb/tb_dadda_mul_pipe.sv
// Testbench for dadda_mul_pipe (WIDTH=8, STAGES=2, TAG_W=4).
// The driver changes inputs 1 time unit after each rising edge. All sampling
// happens on the falling edge. A monitor pushes expected products into a
// scoreboard queue on every accepted beat. It pops and compares the queue on
// every output transfer.
module tb_dadda_mul_pipe;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush_i;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic [TAG_W-1:0]     tag_i;
    logic                 tc_i;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   z_o;
    logic [TAG_W-1:0]     tag_o;

    int checks = 0;
    int errors = 0;
    int outs   = 0;

    typedef struct packed {
        logic [15:0] z;
        logic [3:0]  tag;
    } beat_t;

    beat_t       sb[$];
    beat_t       mon_e;
    logic        hold_v = 1'b0;
    logic [15:0] hold_z;
    logic [3:0]  hold_t;

    dadda_mul_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_i(a_i), .b_i(b_i), .tag_i(tag_i), .tc_i(tc_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .z_o(z_o), .tag_o(tag_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(logic [7:0] a, logic [7:0] b, logic tc);
        logic        smode;
        logic [15:0] sa;
        logic [15:0] sbv;
`ifdef DADDA_SIGNED_EN
        smode = tc;
`else
        smode = 1'b0 & tc;
`endif
        sa  = {{8{a[7]}}, a};
        sbv = {{8{b[7]}}, b};
        if (smode) return 16'($signed(sa) * $signed(sbv));
        return {8'b0, a} * {8'b0, b};
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_z", 32'(z_o), 32'(hold_z));
                check("stall_tag", 32'(tag_o), 32'(hold_t));
            end
            hold_v = 1'b0;
            if (flush_i) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    outs++;
                    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        mon_e = sb.pop_front();
                        check("sb_z", 32'(z_o), 32'(mon_e.z));
                        check("sb_tag", 32'(tag_o), 32'(mon_e.tag));
                    end
                end else if (out_valid) begin
                    hold_v = 1'b1;
                    hold_z = z_o;
                    hold_t = tag_o;
                end
                if (in_valid && in_ready) begin
                    mon_e.z   = model(a_i, b_i, tc_i);
                    mon_e.tag = tag_i;
                    sb.push_back(mon_e);
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t,
                        input logic tc, output int waits);
        a_i = a; b_i = b; tag_i = t; tc_i = tc; in_valid = 1'b1;
        waits = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (n == 59) check("send_timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input logic [15:0] ez, input logic [3:0] et);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                check(name, 32'(z_o), 32'(ez));
                check({name, "_tag"}, 32'(tag_o), 32'(et));
                break;
            end
            if (n == 39) check({name, "_timeout"}, 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) break;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int tot;
        int acc;
        int base;

        rst_n = 1'b0; flush_i = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; a_i = 8'hFF; b_i = 8'hFF; tag_i = 4'd3; tc_i = 1'b0;

        // Reset held with a beat presented
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_z", 32'(z_o), 32'd0);
        check("rst_tag", 32'(tag_o), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_release0", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("ready_release1", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < STAGES - 1; k++) begin
            @(negedge clk);
            check("lat_early", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("ff_x_ff", 32'(z_o), 32'hFE01);
        check("ff_x_ff_tag", 32'(tag_o), 32'd3);
        @(posedge clk); #1;

        // Directed unsigned vectors
        send(8'h00, 8'hA5, 4'd5, 1'b0, w);
        wait_out("zero_op", 16'h0000, 4'd5);
        send(8'h80, 8'h02, 4'd6, 1'b0, w);
        wait_out("pow2", 16'h0100, 4'd6);

        // Back-to-back random beats
        base = outs;
        tot  = 0;
        for (int i = 0; i < 256; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'(i), 1'b0, w);
            in_valid = 1'b1;
            tot += w;
        end
        in_valid = 1'b0;
        check("stream_stalls", 32'(tot), 32'd0);
        drain();
        check("stream_count", 32'(outs - base), 32'd256);

        // Backpressure: out_ready low for 10 clocks
        base = outs;
        acc  = 0;
        out_ready = 1'b0;
        a_i = 8'($urandom_range(0, 255)); b_i = 8'($urandom_range(0, 255));
        tag_i = 4'd9; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
            if (acc > 0 && a_i != 8'h5A && k == acc - 1) begin
                a_i = 8'($urandom_range(0, 255)); b_i = 8'($urandom_range(0, 255));
                tag_i = tag_i + 4'd1;
            end
        end
        check("stall_absorbed", 32'(acc), 32'(STAGES));
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        drain();
        check("stall_release_count", 32'(outs - base), 32'(acc));

        // Flush with two beats in flight and an input beat presented
        out_ready = 1'b0;
        send(8'h11, 8'h22, 4'd1, 1'b0, w);
        send(8'h33, 8'h44, 4'd2, 1'b0, w);
        a_i = 8'h0F; b_i = 8'h0E; tag_i = 4'd12; in_valid = 1'b1;
        flush_i = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        base = outs;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out("post_flush", 16'h00D2, 4'd12);
        drain();
        check("flush_count", 32'(outs - base), 32'd1);

        // Two's-complement mode
`ifdef DADDA_SIGNED_EN
        send(8'h80, 8'h80, 4'd7, 1'b1, w);
        wait_out("s_80x80", 16'h4000, 4'd7);
        send(8'hFF, 8'h01, 4'd8, 1'b1, w);
        wait_out("s_ffx01", 16'hFFFF, 4'd8);
        send(8'h7F, 8'h80, 4'd9, 1'b1, w);
        wait_out("s_7fx80", 16'hC080, 4'd9);
        send(8'hFF, 8'h01, 4'd10, 1'b0, w);
        wait_out("u_ffx01", 16'h00FF, 4'd10);
`else
        send(8'hFF, 8'h01, 4'd8, 1'b1, w);
        wait_out("tc_ignored_ffx01", 16'h00FF, 4'd8);
        send(8'h7F, 8'h80, 4'd9, 1'b1, w);
        wait_out("tc_ignored_7fx80", 16'h3F80, 4'd9);
`endif

        // Reset mid-operation
        out_ready = 1'b0;
        send(8'h12, 8'h34, 4'd4, 1'b0, w);
        send(8'h56, 8'h78, 4'd5, 1'b0, w);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        base = outs;
        repeat (4) @(negedge clk);
        check("midrst_no_output", 32'(outs - base), 32'd0);
        @(posedge clk); #1;
        send(8'hC3, 8'h3C, 4'd15, 1'b0, w);
        wait_out("post_reset", 16'h2DB4, 4'd15);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
